serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the team's existing `fa` full-adder cell, plus a registered carry loop.
- Loads two WIDTH-bit operands and a carry-in on a start handshake.
- Adds one bit per clock, LSB first, and presents the registered sum and carry-out with a one-cycle done pulse.
- Used where area matters more than latency, feeding downstream accumulate/compare logic.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 2.

Ports:
- clk_in  input  1  rising-edge clock
- rst_in  input  1  synchronous reset, active-high
- start_in  input  1  request to begin an addition; sampled only when ready_out=1
- a_in  input  WIDTH  operand A; captured on accepted start
- b_in  input  WIDTH  operand B; captured on accepted start
- carry_in  input  1  carry-in; captured on accepted start
- ready_out  output  1  high in IDLE; block can accept start_in
- busy_out  output  1  high while bits are being processed (RUN)
- done_out  output  1  single-cycle pulse; sum_out/carry_out valid and final
- sum_out  output  WIDTH  registered result; holds until next completion
- carry_out  output  1  registered final carry; holds until next completion

Behaviour:
- Reset values: ready_out=1, busy_out=0, done_out=0, sum_out=0, carry_out=0, state=IDLE, internal shift registers, carry register and counter all 0.
- Reset mid-operation aborts immediately; no done_out is produced for the aborted operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready_out=1.
  - start_in=1 at edge E0: load a_sh<=a_in, b_sh<=b_in, c_reg<=carry_in, cnt<=0, go to RUN.
  - start_in=0: stay in IDLE.
- RUN:
  - busy_out=1, ready_out=0.
  - Each edge, `fa` computes a_sh[0]+b_sh[0]+c_reg.
  - Sum bit shifts into the MSB of internal s_sh (right shift); a_sh and b_sh shift right; c_reg<=fa carry; cnt<=cnt+1.
  - When cnt=WIDTH-1 at an edge, that is the last bit:
    - sum_out<=final s_sh value including this bit; carry_out<=fa carry.
    - Go to DONE.
- DONE:
  - done_out=1 for exactly one cycle; busy_out=0, ready_out=0.
  - Next edge returns to IDLE.
- Latency: start sampled at E0 → done_out high in the cycle following edge E_WIDTH. Throughput is one operation per WIDTH+2 cycles.
- start_in is ignored in RUN and DONE; operand/carry input changes after acceptance have no effect.
- Output stability: sum_out and carry_out change only at the completing edge, never during RUN. They hold their value through IDLE and the next RUN.
- Arithmetic is unsigned modulo 2^WIDTH; overflow is reported only via carry_out.
- cnt width is $clog2(WIDTH); no wrap occurs because the state exits RUN at WIDTH-1.
- start_in held continuously high: a new operation is accepted in every IDLE cycle (one IDLE cycle between operations).
- rst_in has priority over all other events on the same edge, including start acceptance and completion.

Decomposition:
- Shared package arith_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - a counter-width helper constant derived from WIDTH.
- Single sub-module: one instance of the existing `fa` cell for the bit-slice add. Carry, shift and FSM logic stay in serial_adder.

Test Plan (WIDTH=8):
- a=0x5A, b=0x33, cin=0, start at E0 → done_out high in cycle after E8; sum_out=0x8D, carry_out=0; busy_out high for exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum_out=0x00, carry_out=1 (full carry ripple through all bits).
- a=0xFF, b=0xFF, cin=1 → sum_out=0xFF, carry_out=1; then a=0x00, b=0x00, cin=0 → sum_out=0x00, carry_out=0 (no stale carry).
- Start 0x10+0x20; at cycle 3 of RUN, pulse start_in with a=0xAA, b=0x55 → second start ignored; result 0x30, carry 0; ready_out stays 0 until IDLE.
- Reset asserted at RUN cycle 4 of 0xF0+0x0F → next cycle all outputs at reset values, ready_out=1, no done_out. Then start 0x01+0x01 → sum_out=0x02.
- start_in held high with operands 0x80+0x80 → done every 10 cycles, each giving sum_out=0x00, carry_out=1; sum_out stable between done pulses.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-block definitions: FSM state encodings and the
// sizing helper used by the bit-serial datapaths.
package arith_pkg;

    // Raw state encodings, kept as plain constants so other blocks and
    // checkers can compare against them without importing the enum type.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Serial adder control states, bound to the raw encodings above.
    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

    // Width of a counter that must index bit positions 0 .. w-1.
    // Never narrower than one bit so a 2-bit datapath still gets a counter.
    function automatic int cnt_width(input int w);
        if (w <= 2) begin
            return 1;
        end else begin
            return $clog2(w);
        end
    endfunction

endpackage : arith_pkg

// File: rtl/fa.sv
// Single-bit full adder cell shared by the serial arithmetic blocks.
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Purely combinational sum and majority-carry of the three input bits.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule : fa

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are captured on an accepted start,
// one bit per clock is added LSB first through a single fa cell, and the
// registered sum/carry are published together with a one-cycle done pulse.
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
    output logic             ready_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    // Control state.
    state_e state_r;
    state_e state_next_s;

    // Operand, partial-sum and carry loop registers.
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] s_sh_r;
    logic             c_r;
    logic [CW-1:0]    cnt_r;

    // Published result and status flags (all registered).
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;

    // Bit-slice add results and derived datapath values.
    logic             fa_sum_s;
    logic             fa_co_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] s_next_s;

    // One full-adder slice works on the current LSBs and the looped carry.
    fa u_fa (
        .a  (a_sh_r[0]),
        .b  (b_sh_r[0]),
        .ci (c_r),
        .s  (fa_sum_s),
        .co (fa_co_s)
    );

    // Partial sum after this bit and detection of the final bit position.
    always_comb begin
        s_next_s   = {fa_sum_s, s_sh_r[WIDTH-1:1]};
        last_bit_s = (cnt_r == CNT_LAST);
    end

    // State register; reset wins over every other event on the same edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode: accept start only in IDLE, leave RUN after the last bit.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_in) begin
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_bit_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DONE: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // Operand capture, right-shifting datapath, carry loop and bit counter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_sh_r <= {WIDTH{1'b0}};
            b_sh_r <= {WIDTH{1'b0}};
            s_sh_r <= {WIDTH{1'b0}};
            c_r    <= 1'b0;
            cnt_r  <= CNT_ZERO;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_in) begin
                        a_sh_r <= a_in;
                        b_sh_r <= b_in;
                        s_sh_r <= {WIDTH{1'b0}};
                        c_r    <= carry_in;
                        cnt_r  <= CNT_ZERO;
                    end else begin
                        cnt_r  <= cnt_r;
                    end
                end
                S_RUN: begin
                    a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    s_sh_r <= s_next_s;
                    c_r    <= fa_co_s;
                    // Park the counter at zero on the last bit instead of wrapping.
                    if (last_bit_s) begin
                        cnt_r <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Result registers change only on the completing edge and hold otherwise.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
        end else if ((state_r == S_RUN) && last_bit_s) begin
            sum_r   <= s_next_s;
            carry_r <= fa_co_s;
        end else begin
            sum_r   <= sum_r;
            carry_r <= carry_r;
        end
    end

    // Status flags registered from the next state so they align with it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (state_next_s == S_IDLE);
            busy_r  <= (state_next_s == S_RUN);
            done_r  <= (state_next_s == S_DONE);
        end
    end

    // Drive ports straight from registers.
    assign ready_out = ready_r;
    assign busy_out  = busy_r;
    assign done_out  = done_r;
    assign sum_out   = sum_r;
    assign carry_out = carry_r;

endmodule : serial_adder
